// File: rtl/arm_encode.sv
// arm_encode: field-level requests in, packed 32-bit ARM instruction words out.
// Optional ARM_ENCODE_ROT_FAST_EN: resolve DP-immediate rotation in the accept cycle.
module arm_encode (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [3:0]  req_cond,
    input  logic [3:0]  req_opcode,
    input  logic        req_s,
    input  logic [3:0]  req_rn,
    input  logic [3:0]  req_rd,
    input  logic [3:0]  req_rm,
    input  logic [1:0]  req_shift,
    input  logic [4:0]  req_shift_amt,
    input  logic [31:0] req_imm,
    input  logic        req_link,
    input  logic        req_load,
    input  logic        req_up,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic        inst_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  rot, rot_nx;
    logic [31:0] inst_nx;
    logic        err_nx;
    logic        cap;

    logic [3:0]  cond_q, opcode_q, rn_q, rd_q;
    logic        s_q;
    logic [31:0] imm_q;
    logic [31:0] srch_v;

    // rotate left by twice the 4-bit rotation field
    function automatic logic [31:0] rol2(input logic [31:0] v,
                                         input logic [3:0]  r);
        logic [63:0] t;
        t = {v, v} << {r, 1'b0};
        return t[63:32];
    endfunction

    assign req_ready  = (state == IDLE);
    assign inst_valid = (state == OUT);
    assign srch_v     = rol2(imm_q, rot);

`ifdef ARM_ENCODE_ROT_FAST_EN
    logic        fast_hit;
    logic [3:0]  fast_rot;
    logic [31:0] fast_t;
    logic [7:0]  fast_imm8;

    // scan all rotations from the top down so the lowest match wins
    always_comb begin
        fast_hit  = 1'b0;
        fast_rot  = 4'd0;
        fast_t    = 32'd0;
        fast_imm8 = 8'd0;
        for (int i = 15; i >= 0; i--) begin
            fast_t = rol2(req_imm, 4'(i));
            if (fast_t[31:8] == 24'd0) begin
                fast_hit  = 1'b1;
                fast_rot  = 4'(i);
                fast_imm8 = fast_t[7:0];
            end
        end
    end
`endif

    // next-state, capture strobe and next output word
    always_comb begin
        state_nx = state;
        rot_nx   = rot;
        inst_nx  = inst;
        err_nx   = inst_err;
        cap      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    cap      = 1'b1;
                    state_nx = OUT;
                    err_nx   = 1'b0;
                    unique case (req_kind)
                        2'b00: begin
                            inst_nx = {req_cond, 3'b000, req_opcode, req_s,
                                       req_rn, req_rd, req_shift_amt,
                                       req_shift, 1'b0, req_rm};
                        end
                        2'b01: begin
`ifdef ARM_ENCODE_ROT_FAST_EN
                            if (fast_hit) begin
                                inst_nx = {req_cond, 3'b001, req_opcode,
                                           req_s, req_rn, req_rd,
                                           fast_rot, fast_imm8};
                            end else begin
                                inst_nx = 32'd0;
                                err_nx  = 1'b1;
                            end
`else
                            state_nx = SEARCH;
                            rot_nx   = 4'd0;
`endif
                        end
                        2'b10: begin
                            if (&req_imm[31:23] || ~|req_imm[31:23]) begin
                                inst_nx = {req_cond, 3'b101, req_link,
                                           req_imm[23:0]};
                            end else begin
                                inst_nx = 32'd0;
                                err_nx  = 1'b1;
                            end
                        end
                        2'b11: begin
                            if (~|req_imm[31:12]) begin
                                inst_nx = {req_cond, 3'b010, 1'b1, req_up,
                                           1'b0, 1'b0, req_load, req_rn,
                                           req_rd, req_imm[11:0]};
                            end else begin
                                inst_nx = 32'd0;
                                err_nx  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SEARCH: begin
                if (srch_v[31:8] == 24'd0) begin
                    inst_nx  = {cond_q, 3'b001, opcode_q, s_q, rn_q, rd_q,
                                rot, srch_v[7:0]};
                    err_nx   = 1'b0;
                    state_nx = OUT;
                end else if (rot == 4'd15) begin
                    inst_nx  = 32'd0;
                    err_nx   = 1'b1;
                    state_nx = OUT;
                end else begin
                    rot_nx = rot + 4'd1;
                end
            end
            OUT: begin
                if (inst_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state, rotation counter, output word and captured request fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rot      <= 4'd0;
            inst     <= 32'd0;
            inst_err <= 1'b0;
            cond_q   <= 4'd0;
            opcode_q <= 4'd0;
            s_q      <= 1'b0;
            rn_q     <= 4'd0;
            rd_q     <= 4'd0;
            imm_q    <= 32'd0;
        end else begin
            state    <= state_nx;
            rot      <= rot_nx;
            inst     <= inst_nx;
            inst_err <= err_nx;
            if (cap) begin
                cond_q   <= req_cond;
                opcode_q <= req_opcode;
                s_q      <= req_s;
                rn_q     <= req_rn;
                rd_q     <= req_rd;
                imm_q    <= req_imm;
            end
        end
    end

endmodule
